pg_alu_domain_ctrl: RTL and testbench

- Power-gated ALU subsystem with an integrated power/isolation sequencer.
- Generalises the fixed 16-bit ALU wrapper: parametrised width, clamp value and sequencing delays; adds a start/done handshake, a multi-cycle multiply, and automatic isolate-before-off / power-before-deisolate ordering.
- Sits between the core datapath and the always-on power controller. Downstream logic sees only clamped or valid results.

---
 rtl/pg_alu_domain_ctrl_if.sv | 31 +++
 rtl/pg_alu_domain_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pg_alu_domain_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pg_alu_domain_ctrl_if.sv
// Core-side bundle for the power-gated ALU domain: operands, start/done
// handshake, power request and the sequencer's power/isolation outputs.
interface pg_alu_domain_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             pwr_req;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       opcode;
    logic             start;
    logic             alu_pwr_en;
    logic             iso_en;
    logic             pwr_ack;
    logic             busy;
    logic             done;
    logic             start_err;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] clamp_obs;

    modport master (
        output pwr_req, A, B, opcode, start,
        input  alu_pwr_en, iso_en, pwr_ack, busy, done, start_err,
        input  result, clamp_obs
    );

    modport slave (
        input  pwr_req, A, B, opcode, start,
        output alu_pwr_en, iso_en, pwr_ack, busy, done, start_err,
        output result, clamp_obs
    );
endinterface

// File: rtl/pg_alu_domain_ctrl.sv
// Power-gated ALU with isolate-before-off / power-before-deisolate sequencing.
// PG_ALU_RETENTION_EN: result register keeps its value across a power cycle.
module pg_alu_domain_ctrl #(
    parameter int               WIDTH         = 16,
    parameter logic [WIDTH-1:0] CLAMP_VAL     = '0,
    parameter int               PWR_UP_CYCLES = 4,
    parameter int               ISO_CYCLES    = 2
) (
    input logic           clk,
    input logic           rst_n,
    pg_alu_domain_ctrl_if.slave bus
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int SEQM = (PWR_UP_CYCLES > ISO_CYCLES) ? PWR_UP_CYCLES : ISO_CYCLES;
    localparam int CMAX = (SEQM > WIDTH) ? SEQM : WIDTH;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        OFF, PWR_UP, DEISO, IDLE, BUSY, ISO, PWR_DN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             err_pend_q, err_pend_d;
    logic [WIDTH-1:0] alu_res;
    logic             op_legal;
    logic             op_mul;
    logic             reject;

    assign op_legal = (bus.opcode <= 4'd8);
    assign op_mul   = (bus.opcode == 4'd8);
    assign reject   = bus.start && ((state_q != IDLE) || !op_legal);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= OFF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OFF:    if (bus.pwr_req) state_d = PWR_UP;
            PWR_UP: if (cnt_q == CW'(PWR_UP_CYCLES - 1)) state_d = DEISO;
            DEISO:  if (cnt_q == CW'(ISO_CYCLES - 1)) state_d = IDLE;
            IDLE: begin
                if (bus.start) begin
                    if (op_legal) state_d = BUSY;
                end else if (!bus.pwr_req) begin
                    state_d = ISO;
                end
            end
            BUSY:   if (done_q) state_d = IDLE;
            ISO:    if (cnt_q == CW'(ISO_CYCLES - 1)) state_d = PWR_DN;
            PWR_DN: state_d = OFF;
            default: state_d = OFF;
        endcase
    end

    always_comb begin
        bus.alu_pwr_en = 1'b1;
        bus.iso_en     = 1'b1;
        bus.pwr_ack    = 1'b0;
        bus.busy       = 1'b0;
        unique case (state_q)
            OFF, PWR_DN: bus.alu_pwr_en = 1'b0;
            IDLE: begin
                bus.iso_en  = 1'b0;
                bus.pwr_ack = 1'b1;
            end
            BUSY: begin
                bus.iso_en  = 1'b0;
                bus.pwr_ack = 1'b1;
                bus.busy    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.opcode)
            4'd0:    alu_res = bus.A + bus.B;
            4'd1:    alu_res = bus.A - bus.B;
            4'd2:    alu_res = bus.A & bus.B;
            4'd3:    alu_res = bus.A | bus.B;
            4'd4:    alu_res = bus.A ^ bus.B;
            4'd5:    alu_res = ~bus.A;
            4'd6:    alu_res = bus.A << bus.B[SHW-1:0];
            4'd7:    alu_res = bus.A >> bus.B[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    // Multiply retires bit 0 on the accept edge, so WIDTH-1 more steps remain.
    always_comb begin
        result_d = result_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        done_d   = 1'b0;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q inside {PWR_UP, DEISO, BUSY, ISO}) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
        unique case (state_q)
            OFF: begin
`ifdef PG_ALU_RETENTION_EN
                result_d = result_q;
`else
                if (state_d == PWR_UP) result_d = '0;
`endif
            end
            IDLE: begin
                if (bus.start && op_legal) begin
                    if (op_mul) begin
                        acc_d    = bus.B[0] ? bus.A : '0;
                        mcand_d  = bus.A << 1;
                        mplier_d = bus.B >> 1;
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!done_q) begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CW'(WIDTH - 2)) begin
                        result_d = acc_d;
                        done_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // A reject landing on a done cycle is reported one cycle later.
        err_d      = (reject && !done_d) || err_pend_q;
        err_pend_d = reject && done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            result_q   <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign bus.done      = done_q;
    assign bus.start_err = err_q;
    assign bus.result    = bus.iso_en ? CLAMP_VAL : result_q;
    assign bus.clamp_obs = CLAMP_VAL;
endmodule

// File: tb/tb_pg_alu_domain_ctrl.sv
// Scoreboard bench for pg_alu_domain_ctrl: sequencing, ALU ops,
// multiply latency, deferred power-down, rejected starts and reset abort.
module tb_pg_alu_domain_ctrl;
    localparam int          W    = 16;
    localparam logic [15:0] CLMP = 16'h0000;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   n;
    logic [15:0] sb_q[$];
    logic [15:0] exp_ret;

    pg_alu_domain_ctrl_if #(.WIDTH(W)) bus ();

    pg_alu_domain_ctrl #(
        .WIDTH(W),
        .CLAMP_VAL(CLMP),
        .PWR_UP_CYCLES(4),
        .ISO_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("iso_inv", {31'd0, !bus.alu_pwr_en && !bus.iso_en}, 0);
            chk("done_err", {31'd0, bus.done && bus.start_err}, 0);
            if (bus.iso_en) chk("clamp", bus.result, CLMP);
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    chk("sb_result", bus.result, sb_q.pop_front());
                end
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] opc, input logic [15:0] exp,
                          input int lat);
        bus.A      = a;
        bus.B      = b;
        bus.opcode = opc;
        bus.start  = 1'b1;
        sb_q.push_back(exp);
        tick();
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        chk("op_busy", bus.busy, 1);
        n = 1;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
        chk("op_lat", n, lat);
        tick();
        chk("op_idle", bus.busy, 0);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        bus.pwr_req = 1'b0;
        bus.start   = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.opcode  = '0;
        repeat (3) tick();
        chk("rst_pwr", bus.alu_pwr_en, 0);
        chk("rst_iso", bus.iso_en, 1);
        chk("rst_ack", bus.pwr_ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.start_err, 0);
        chk("rst_res", bus.result, CLMP);
        chk("clamp_obs", bus.clamp_obs, CLMP);
        rst_n = 1'b1;
        tick();

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("off_rej", bus.start_err, 1);
        chk("off_stay", bus.alu_pwr_en, 0);
        tick();
        chk("off_rej_pulse", bus.start_err, 0);

        bus.pwr_req = 1'b1;
        tick();
        chk("pwr_rise", bus.alu_pwr_en, 1);
        chk("pwr_iso", bus.iso_en, 1);
        n = 0;
        while (bus.iso_en && n < 20) begin
            tick();
            n++;
        end
        chk("deiso_lat", n, 6);
        chk("up_ack", bus.pwr_ack, 1);
        chk("up_res", bus.result, 16'h0000);

        run_op(16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1);
        run_op(16'h0005, 16'h0007, 4'd1, 16'hFFFE, 1);
        run_op(16'hF0F0, 16'h3C3C, 4'd2, 16'h3030, 1);
        run_op(16'hF0F0, 16'h0F00, 4'd3, 16'hFFF0, 1);
        run_op(16'hAAAA, 16'hFFFF, 4'd4, 16'h5555, 1);
        run_op(16'h1234, 16'h0000, 4'd5, 16'hEDCB, 1);
        run_op(16'h0001, 16'h0013, 4'd6, 16'h0008, 1);
        run_op(16'h8000, 16'h001F, 4'd7, 16'h0001, 1);
        run_op(16'hFFFF, 16'hFFFF, 4'd8, 16'h0001, 16);
        run_op(16'h0123, 16'h0010, 4'd8, 16'h1230, 16);

        bus.opcode = 4'd12;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("ill_err", bus.start_err, 1);
        chk("ill_done", bus.done, 0);
        chk("ill_res", bus.result, 16'h1230);
        chk("ill_idle", bus.pwr_ack, 1);
        tick();
        chk("ill_pulse", bus.start_err, 0);

        bus.A      = 16'h0123;
        bus.B      = 16'h0010;
        bus.opcode = 4'd8;
        bus.start  = 1'b1;
        sb_q.push_back(16'h1230);
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 40) begin
            if (n == 3) bus.pwr_req = 1'b0;
            if (n == 5) bus.start = 1'b1;
            tick();
            n++;
            if (bus.start) begin
                bus.start = 1'b0;
                chk("busy_rej", bus.start_err, 1);
                chk("busy_ack", bus.pwr_ack, 1);
            end
        end
        chk("defer_lat", n, 16);
        chk("defer_iso", bus.iso_en, 0);
        n = 0;
        while (!bus.iso_en && n < 10) begin
            tick();
            n++;
        end
        chk("iso_delay", n, 2);
        chk("iso_pwr", bus.alu_pwr_en, 1);
        chk("iso_ack", bus.pwr_ack, 0);
        n = 0;
        while (bus.alu_pwr_en && n < 10) begin
            tick();
            n++;
        end
        chk("pd_delay", n, 2);
        tick();
        chk("off_pwr", bus.alu_pwr_en, 0);
        chk("off_iso", bus.iso_en, 1);

`ifdef PG_ALU_RETENTION_EN
        exp_ret = 16'h1230;
`else
        exp_ret = 16'h0000;
`endif
        bus.pwr_req = 1'b1;
        n = 0;
        while (!bus.pwr_ack && n < 20) begin
            tick();
            n++;
        end
        chk("up2_lat", n, 7);
        chk("retain", bus.result, exp_ret);

        bus.A      = 16'h0003;
        bus.B      = 16'h0005;
        bus.opcode = 4'd8;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        chk("abort_busy", bus.busy, 1);
        bus.pwr_req = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("abort_pwr", bus.alu_pwr_en, 0);
        chk("abort_iso", bus.iso_en, 1);
        chk("abort_busy0", bus.busy, 0);
        chk("abort_res", bus.result, CLMP);
        chk("abort_ack", bus.pwr_ack, 0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("abort_off", bus.alu_pwr_en, 0);
        chk("sb_left", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
